// File: rtl/btn_conditioner.sv
// ============================================================================
// Module      : btn_conditioner
// Description : Two-flop synchronizer, per-channel debounce FSM with registered
//               press/release pulses; optional long-press pulse (BTN_LONGPRESS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic             clk,
    input  logic             resetBtn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    localparam int c_CW = $clog2(DEBOUNCE_CYCLES);
    // The edge that leaves IDLE/PRESSED already counts as the first stable sample.
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 2);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_check
        $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
    end

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (!resetBtn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        state_t          r_state;
        state_t          w_state_nxt;
        logic [c_CW-1:0] r_cnt;
        logic [c_CW-1:0] w_cnt_nxt;
        logic            r_level;
        logic            r_press;
        logic            r_release;
        logic            w_level_nxt;
        logic            w_press_nxt;
        logic            w_release_nxt;
        logic            w_s;

        assign w_s = r_sync2[i];

        always_ff @(posedge clk) begin
            if (!resetBtn) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_level   <= w_level_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
            end
        end

        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_level_nxt   = r_level;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_s) begin
                        w_state_nxt = S_PRESS_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!w_s) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!w_s) begin
                        w_state_nxt = S_RELEASE_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (w_s) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt   = S_IDLE;
                        w_cnt_nxt     = '0;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end
            endcase
        end

        assign btn_level[i]   = r_level;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;

`ifdef BTN_LONGPRESS_EN
        localparam int              c_LW      = $clog2(LONG_CYCLES + 1);
        localparam logic [c_LW-1:0] c_LONG    = c_LW'(LONG_CYCLES);
        localparam logic [c_LW-1:0] c_LONG_M1 = c_LW'(LONG_CYCLES - 1);

        logic [c_LW-1:0] r_hold;
        logic            r_long;

        // Saturating at LONG_CYCLES guarantees a single pulse per press.
        always_ff @(posedge clk) begin
            if (!resetBtn) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else begin
                r_long <= 1'b0;
                if (r_state == S_PRESS_WAIT && w_state_nxt == S_PRESSED) begin
                    r_hold <= '0;
                end else if ((r_state == S_PRESSED || r_state == S_RELEASE_WAIT) &&
                             r_hold != c_LONG) begin
                    r_hold <= r_hold + 1'b1;
                    if (r_hold == c_LONG_M1) begin
                        r_long <= 1'b1;
                    end
                end
            end
        end

        assign btn_long[i] = r_long;
`else
        assign btn_long[i] = 1'b0;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
// Module      : tb_btn_conditioner
// Description : Self-checking bench for btn_conditioner (vector table, directed
//               corner sequences, randomized run against a run-length model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_conditioner;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int LC = 10;
`ifdef BTN_LONGPRESS_EN
    localparam int LONG_ON = 1;
`else
    localparam int LONG_ON = 0;
`endif

    logic         clk = 1'b0;
    logic         resetBtn = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;

    btn_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LC)
    ) dut (
        .clk        (clk),
        .resetBtn   (resetBtn),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: s is raw from two edges ago; level follows s once s has
    // disagreed with it on DB consecutive edges.
    logic [N-1:0] m_s1, m_s2, m_level, e_press, e_rel, e_long;
    int           m_run  [N];
    int           m_hold [N];

    int stepno;
    int n_press [N];
    int n_rel   [N];
    int n_long  [N];
    int n_hi    [N];
    int f_press [N];
    int f_rel   [N];
    int f_long  [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic rst_n, input logic [N-1:0] raw);
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        if (!rst_n) begin
            m_s1    = '0;
            m_s2    = '0;
            m_level = '0;
            for (int c = 0; c < N; c++) begin
                m_run[c]  = 0;
                m_hold[c] = 0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                logic s;
                logic was_hi;
                s      = m_s2[c];
                was_hi = m_level[c];
                if (LONG_ON != 0 && was_hi && m_hold[c] < LC) begin
                    m_hold[c]++;
                    if (m_hold[c] == LC) e_long[c] = 1'b1;
                end
                if (s != m_level[c]) m_run[c]++;
                else                 m_run[c] = 0;
                if (m_run[c] == DB) begin
                    m_level[c] = s;
                    m_run[c]   = 0;
                    if (s) begin
                        e_press[c] = 1'b1;
                        m_hold[c]  = 0;
                    end else begin
                        e_rel[c] = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    task automatic clr_counts();
        stepno = 0;
        for (int c = 0; c < N; c++) begin
            n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_hi[c] = 0;
            f_press[c] = 0; f_rel[c] = 0; f_long[c] = 0;
        end
    endtask

    task automatic step(input logic rst_n, input logic [N-1:0] raw);
        resetBtn = rst_n;
        btn_raw  = raw;
        @(posedge clk);
        model(rst_n, raw);
        #1;
        stepno++;
        check("level",   {28'd0, btn_level},   {28'd0, m_level});
        check("press",   {28'd0, btn_press},   {28'd0, e_press});
        check("release", {28'd0, btn_release}, {28'd0, e_rel});
        check("long",    {28'd0, btn_long},    {28'd0, e_long});
        check("press_and_release_same_cycle", {28'd0, btn_press & btn_release}, 32'd0);
        for (int c = 0; c < N; c++) begin
            if (btn_press[c])   begin n_press[c]++; if (f_press[c] == 0) f_press[c] = stepno; end
            if (btn_release[c]) begin n_rel[c]++;   if (f_rel[c] == 0)   f_rel[c]   = stepno; end
            if (btn_long[c])    begin n_long[c]++;  if (f_long[c] == 0)  f_long[c]  = stepno; end
            if (btn_level[c])   n_hi[c]++;
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) step(1'b0, btn_raw);
    endtask

    typedef struct {
        logic         rst_n;
        logic [N-1:0] raw;
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [N-1:0] r;
        int           lim;

        // Reset with all buttons held, press at 6th edge, release 6 edges after fall.
        for (int k = 0; k < 3; k++) tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 4'h0});
        for (int k = 0; k < 5; k++) tbl.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b1, 4'hF, 4'hF, 4'hF, 4'h0});
        tbl.push_back('{1'b1, 4'hF, 4'hF, 4'h0, 4'h0});
        for (int k = 0; k < 5; k++) tbl.push_back('{1'b1, 4'h0, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b1, 4'h0, 4'h0, 4'h0, 4'hF});
        tbl.push_back('{1'b1, 4'h0, 4'h0, 4'h0, 4'h0});

        clr_counts();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].raw);
            check($sformatf("tbl%0d_level", i), {28'd0, btn_level},   {28'd0, tbl[i].level});
            check($sformatf("tbl%0d_press", i), {28'd0, btn_press},   {28'd0, tbl[i].press});
            check($sformatf("tbl%0d_rel", i),   {28'd0, btn_release}, {28'd0, tbl[i].rel});
        end

        // Single button held 20 cycles.
        do_reset(2);
        clr_counts();
        for (int k = 0; k < 20; k++) step(1'b1, 4'b0001);
        for (int k = 0; k < 10; k++) step(1'b1, 4'b0000);
        check("hold_npress", n_press[0], 1);
        check("hold_fpress", f_press[0], 6);
        check("hold_nrel",   n_rel[0],   1);
        check("hold_frel",   f_rel[0],   26);
        check("hold_nlong",  n_long[0],  LONG_ON);
        check("hold_other",  n_press[1] + n_press[2] + n_press[3], 0);

        // Three-cycle glitch is rejected.
        do_reset(2);
        clr_counts();
        for (int k = 0; k < 3; k++)  step(1'b1, 4'b0010);
        for (int k = 0; k < 10; k++) step(1'b1, 4'b0000);
        check("glitch_npress", n_press[1], 0);
        check("glitch_nrel",   n_rel[1],   0);
        check("glitch_level",  n_hi[1],    0);

        // Bouncing press.
        do_reset(2);
        clr_counts();
        step(1'b1, 4'b0100); step(1'b1, 4'b0000); step(1'b1, 4'b0100);
        step(1'b1, 4'b0100); step(1'b1, 4'b0000);
        for (int k = 0; k < 12; k++) step(1'b1, 4'b0100);
        check("bounce_npress", n_press[2], 1);
        check("bounce_fpress", f_press[2], 11);

        // Simultaneous presses on two channels.
        do_reset(2);
        clr_counts();
        for (int k = 0; k < 10; k++) step(1'b1, 4'b1001);
        check("simul_f0",    f_press[0], 6);
        check("simul_f3",    f_press[3], 6);
        check("simul_other", n_press[1] + n_press[2], 0);

        // Reset in the middle of debounce, then a long hold.
        step(1'b1, 4'b0000);
        do_reset(2);
        clr_counts();
        for (int k = 0; k < 5; k++) step(1'b1, 4'b0001);
        check("midrst_pre_npress", n_press[0], 0);
        step(1'b0, 4'b0001);
        check("midrst_npress", n_press[0], 0);
        clr_counts();
        for (int k = 0; k < 40; k++) step(1'b1, 4'b0001);
        check("midrst_fpress", f_press[0], 6);
        check("midrst_npress2", n_press[0], 1);
        check("long_n", n_long[0], LONG_ON);
        check("long_f", f_long[0], (LONG_ON != 0) ? 16 : 0);
        for (int k = 0; k < 8; k++) step(1'b1, 4'b0000);
        check("long_after_rel", n_long[0], LONG_ON);

        // Randomized run, alternating bouncy and calm phases.
        do_reset(2);
        r = '0;
        for (int k = 0; k < 4000; k++) begin
            lim = ((k / 250) % 2 == 0) ? 3 : 25;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, lim) == 0) r[b] = ~r[b];
            step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
